pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard controller: decoded ID operands in,
// stall/flush/forwarding decisions and the stall counter out.
interface pipe_hazard_ctrl_if #(
    parameter int RW    = 3,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [RW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_load;
    logic          id_branch;
    logic          branch_taken;

    logic             stall;
    logic             flush_ifid;
    logic [SW-1:0]    ex_fwd_a;
    logic [SW-1:0]    ex_fwd_b;
    logic [SW-1:0]    id_fwd_a;
    logic [SW-1:0]    id_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_wr_en, id_load, id_branch, branch_taken,
        input  stall, flush_ifid, ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_wr_en, id_load, id_branch, branch_taken,
        output stall, flush_ifid, ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: tracks the instructions in EX..WB with a tag
// shift register and derives load-use/branch stalls, forwarding selects and a stall count.
module pipe_hazard_ctrl #(
    parameter int RW       = 3,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 2,
    parameter int LD_RDY   = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic [RW-1:0] rd;
        logic          load;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
    } tag_t;

    tag_t             pipe_q [1:DEPTH];
    tag_t             pipe_d [1:DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic          stall;
    logic          use_a;
    logic          use_b;
    int            young_a;
    int            young_b;
    logic          load_a;
    logic          load_b;
    logic [SW-1:0] ex_a;
    logic [SW-1:0] ex_b;
    logic [SW-1:0] id_a;
    logic [SW-1:0] id_b;

    function automatic logic is_producer(tag_t t, logic [RW-1:0] r);
        return t.valid && t.wr_en && (t.rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    function automatic logic is_ready(logic ld, int k);
        return ld ? (k >= LD_RDY) : (k >= ALU_RDY);
    endfunction

    // Only the youngest producer of each ID source decides stalling and ID forwarding;
    // the loop runs oldest-first so the smallest matching stage wins.
    always_comb begin
        young_a = 0;
        young_b = 0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        stall   = 1'b0;
        id_a    = '0;
        id_b    = '0;
        ex_a    = '0;
        ex_b    = '0;
        use_a   = hz.id_valid && hz.id_use_rs;
        use_b   = hz.id_valid && hz.id_use_rt;
        for (int k = DEPTH; k >= 1; k--) begin
            if (is_producer(pipe_q[k], hz.id_rs)) begin
                young_a = k;
                load_a  = pipe_q[k].load;
            end
            if (is_producer(pipe_q[k], hz.id_rt)) begin
                young_b = k;
                load_b  = pipe_q[k].load;
            end
        end
        if (use_a && young_a != 0 &&
            !is_ready(load_a, hz.id_branch ? young_a : young_a + 1)) begin
            stall = 1'b1;
        end
        if (use_b && young_b != 0 &&
            !is_ready(load_b, hz.id_branch ? young_b : young_b + 1)) begin
            stall = 1'b1;
        end
        stall = stall && rst_n;
        if (rst_n && !stall) begin
            if (use_a && young_a != 0 && is_ready(load_a, young_a)) id_a = SW'(young_a);
            if (use_b && young_b != 0 && is_ready(load_b, young_b)) id_b = SW'(young_b);
        end
        // EX selects look at the instruction now in EX against the stages behind it.
        for (int k = DEPTH; k >= 2; k--) begin
            if (rst_n && pipe_q[1].valid && pipe_q[1].use_rs && is_producer(pipe_q[k], pipe_q[1].rs))
                ex_a = SW'(k);
            if (rst_n && pipe_q[1].valid && pipe_q[1].use_rt && is_producer(pipe_q[k], pipe_q[1].rt))
                ex_b = SW'(k);
        end
    end

    always_comb begin
        pipe_d[1] = '0;
        if (hz.id_valid && !stall) begin
            pipe_d[1].valid  = 1'b1;
            pipe_d[1].wr_en  = hz.id_wr_en;
            pipe_d[1].rd     = hz.id_rd;
            pipe_d[1].load   = hz.id_load;
            pipe_d[1].rs     = hz.id_rs;
            pipe_d[1].rt     = hz.id_rt;
            pipe_d[1].use_rs = hz.id_use_rs;
            pipe_d[1].use_rt = hz.id_use_rt;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hz.stall      = stall;
    assign hz.flush_ifid = hz.branch_taken && !stall;
    assign hz.ex_fwd_a   = ex_a;
    assign hz.ex_fwd_b   = ex_b;
    assign hz.id_fwd_a   = id_a;
    assign hz.id_fwd_b   = id_b;
    assign hz.stall_cnt  = rst_n ? cnt_q : '0;
endmodule
